// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong datapath/buttons and the game sequencing controller.
interface pong_game_ctrl_if;
    logic        start;
    logic        frame_tick;
    logic        hit;
    logic        miss;
    logic        ball_run;
    logic        ball_reset;
    logic        game_over;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [2:0]  state;

    modport master (
        output start, frame_tick, hit, miss,
        input  ball_run, ball_reset, game_over, lives, score, state
    );

    modport slave (
        input  start, frame_tick, hit, miss,
        output ball_run, ball_reset, game_over, lives, score, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/pause/over FSM, BCD score and life counter.
// All outputs come straight from flops.
module pong_game_ctrl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic              clk,
    input  logic              reset,
    pong_game_ctrl_if.slave   bus
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned CNT_W   = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    logic [STATE_W-1:0] state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               ball_run_q, ball_run_d;
    logic               ball_reset_q, ball_reset_d;
    logic               game_over_q, game_over_d;
    logic               press;

    // Packed-BCD increment with per-digit carry, saturating at 9999.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign press = bus.start & ~start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            score_q      <= '0;
            cnt_q        <= '0;
            start_q      <= 1'b1;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        cnt_d        = cnt_q;
        start_d      = bus.start;
        ball_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    score_d      = '0;
                    lives_d      = LIVES_W'(LIVES);
                    cnt_d        = '0;
                    ball_reset_d = 1'b1;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt_q + CNT_W'(1) == CNT_W'(SERVE_FRAMES)) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // miss outranks hit, which outranks a pause press
                if (bus.miss) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d      = lives_q - LIVES_W'(1);
                        cnt_d        = '0;
                        ball_reset_d = 1'b1;
                        state_d      = ST_SERVE;
                    end else begin
                        lives_d = '0;
                        state_d = ST_OVER;
                    end
                end else if (bus.hit) begin
                    score_d = bcd_inc(score_q);
                end else if (press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        ball_run_d  = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    assign bus.state      = state_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl (LIVES=2, SERVE_FRAMES=2): vector tables
// plus hand-built sequences, with expected outputs queued and checked after each edge.
module tb_pong_game_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic        run;
        logic        rst;
        logic        over;
        logic [1:0]  lv;
        logic [15:0] sc;
    } exp_t;

    typedef struct packed {
        logic s;
        logic t;
        logic h;
        logic m;
        exp_t e;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(.LIVES(2), .SERVE_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic exp_t mk_e(input logic [2:0] st, input logic run, input logic rst,
                                  input logic over, input logic [1:0] lv, input logic [15:0] sc);
        exp_t e;
        e.st = st; e.run = run; e.rst = rst; e.over = over; e.lv = lv; e.sc = sc;
        return e;
    endfunction

    function automatic vec_t mk(input logic s, input logic t, input logic h, input logic m,
                                input exp_t e);
        vec_t v;
        v.s = s; v.t = t; v.h = h; v.m = m; v.e = e;
        return v;
    endfunction

    function automatic exp_t got_now();
        return mk_e(bus.state, bus.ball_run, bus.ball_reset, bus.game_over, bus.lives, bus.score);
    endfunction

    task automatic compare(input string name, input exp_t exp);
        exp_t got;
        got = got_now();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d run=%0b rst=%0b over=%0b lives=%0d score=%h, exp st=%0d run=%0b rst=%0b over=%0b lives=%0d score=%h",
                     name, got.st, got.run, got.rst, got.over, got.lv, got.sc,
                     exp.st, exp.run, exp.rst, exp.over, exp.lv, exp.sc);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, check it after the edge.
    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        bus.start      = v.s;
        bus.frame_tick = v.t;
        bus.hit        = v.h;
        bus.miss       = v.m;
        exp_q.push_back(v.e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got st=%0d", name, bus.state);
        end else begin
            compare(name, exp_q.pop_front());
        end
    endtask

    task automatic run_tbl(input string name, input vec_t tbl[$]);
        foreach (tbl[i]) step($sformatf("%s[%0d]", name, i), tbl[i]);
    endtask

    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, OVER = 3'd4;

    initial begin
        vec_t t_start[$];
        vec_t t_mid[$];
        vec_t t_over[$];
        exp_t zero;

        checks = 0;
        errors = 0;
        zero   = mk_e(IDLE, 0, 0, 0, 2'd0, 16'h0000);

        // power-up, new game, serve countdown
        t_start.push_back(mk(1, 0, 0, 0, zero));
        t_start.push_back(mk(0, 0, 0, 0, zero));
        t_start.push_back(mk(1, 0, 0, 0, mk_e(SERVE, 0, 1, 0, 2'd2, 16'h0000)));
        t_start.push_back(mk(1, 1, 0, 0, mk_e(SERVE, 0, 0, 0, 2'd2, 16'h0000)));
        t_start.push_back(mk(0, 0, 0, 0, mk_e(SERVE, 0, 0, 0, 2'd2, 16'h0000)));
        t_start.push_back(mk(0, 1, 0, 0, mk_e(PLAY,  1, 0, 0, 2'd2, 16'h0000)));

        // hit+miss together, re-serve, pause with ignored events
        t_mid.push_back(mk(0, 0, 1, 1, mk_e(SERVE, 0, 1, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(0, 1, 0, 0, mk_e(SERVE, 0, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(0, 0, 1, 0, mk_e(SERVE, 0, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(0, 1, 0, 0, mk_e(PLAY,  1, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(1, 0, 0, 0, mk_e(PAUSE, 0, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(1, 0, 1, 0, mk_e(PAUSE, 0, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(0, 0, 0, 1, mk_e(PAUSE, 0, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(0, 1, 0, 0, mk_e(PAUSE, 0, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(1, 0, 0, 0, mk_e(PLAY,  1, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(1, 0, 0, 0, mk_e(PLAY,  1, 0, 0, 2'd1, 16'h0005)));
        t_mid.push_back(mk(0, 0, 0, 0, mk_e(PLAY,  1, 0, 0, 2'd1, 16'h0005)));

        // last life lost (miss beats press), OVER holds, new game
        t_over.push_back(mk(1, 0, 0, 1, mk_e(OVER,  0, 0, 1, 2'd0, 16'h0100)));
        t_over.push_back(mk(0, 0, 1, 0, mk_e(OVER,  0, 0, 1, 2'd0, 16'h0100)));
        t_over.push_back(mk(1, 0, 0, 0, mk_e(SERVE, 0, 1, 0, 2'd2, 16'h0000)));
        t_over.push_back(mk(0, 1, 0, 0, mk_e(SERVE, 0, 0, 0, 2'd2, 16'h0000)));
        t_over.push_back(mk(0, 1, 0, 0, mk_e(PLAY,  1, 0, 0, 2'd2, 16'h0000)));

        reset          = 1'b0;
        bus.start      = 1'b1;
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
        bus.miss       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare("reset_values", zero);
        @(negedge clk);
        reset = 1'b1;

        run_tbl("start", t_start);
        for (int i = 1; i <= 5; i++)
            step($sformatf("hit_a%0d", i), mk(0, 0, 1, 0, mk_e(PLAY, 1, 0, 0, 2'd1 + 2'd1, to_bcd(i))));
        run_tbl("mid", t_mid);
        for (int i = 6; i <= 100; i++)
            step($sformatf("hit_b%0d", i), mk(0, 0, 1, 0, mk_e(PLAY, 1, 0, 0, 2'd1, to_bcd(i))));
        run_tbl("over", t_over);
        for (int i = 1; i <= 10001; i++)
            step($sformatf("hit_c%0d", i),
                 mk(0, 0, 1, 0, mk_e(PLAY, 1, 0, 0, 2'd2, to_bcd(i > 9999 ? 9999 : i))));

        // asynchronous reset between edges
        @(negedge clk);
        bus.hit = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset_mid_cycle", zero);
        @(posedge clk);
        #1;
        compare("async_reset_held", zero);
        @(negedge clk);
        reset = 1'b1;
        step("after_reset_idle", mk(0, 0, 0, 0, zero));
        step("after_reset_press", mk(1, 0, 0, 0, mk_e(SERVE, 0, 1, 0, 2'd2, 16'h0000)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
